// File: rtl/dflow_pkt_builder.sv
// Flow descriptor to Eth/IPv4/L4 frame serialiser (256-bit AXIS, NetFPGA tuser); DFLOW_IP_CSUM_EN adds the IP checksum state.
// Latency accept->first beat 1 cycle (2 with DFLOW_IP_CSUM_EN); beats held stable while tready=0, one descriptor in flight.
module dflow_pkt_builder #(
  parameter int          PKT_TUPLE_WIDTH      = 104,
  parameter int          PKT_LEN_WIDTH        = 16,
  parameter int          C_M_AXIS_DATA_WIDTH  = 256,
  parameter int          C_M_AXIS_TUSER_WIDTH = 128,
  parameter int          MIN_PKT_LEN          = 64,
  parameter int          MAX_PKT_LEN          = 1518,
  parameter logic [47:0] DST_MAC              = 48'h00_11_22_33_44_55,
  parameter logic [47:0] SRC_MAC              = 48'h00_AA_BB_CC_DD_EE,
  parameter logic [7:0]  TUSER_SRC_PORT       = 8'h00,
  parameter logic [7:0]  TUSER_DST_PORT       = 8'h01
) (
  input  logic                                 qdr_clk,
  input  logic                                 reset,
  input  logic [PKT_TUPLE_WIDTH-1:0]           fivetuple_data_in,
  input  logic [PKT_LEN_WIDTH-1:0]             pkt_len_in,
  input  logic                                 tuple_in_vld,
  output logic                                 tuple_in_ready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 m_axis_tlast,
  output logic [31:0]                          pkt_cnt
);

  typedef enum logic [2:0] {IDLE, CSUM, HDR0, HDR1, BODY} state_t;

  localparam logic [PKT_LEN_WIDTH-1:0] MIN_L = PKT_LEN_WIDTH'(MIN_PKT_LEN);
  localparam logic [PKT_LEN_WIDTH-1:0] MAX_L = PKT_LEN_WIDTH'(MAX_PKT_LEN);

  state_t                            state_q, state_d;
  logic [PKT_TUPLE_WIDTH-1:0]        tuple_q, tuple_d;
  logic [PKT_LEN_WIDTH-1:0]          len_q, len_d, beat_q, beat_d;
  logic [15:0]                       id_q, id_d;
  logic [C_M_AXIS_DATA_WIDTH-1:0]    tdata_q, tdata_d;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0]  tkeep_q, tkeep_d;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]   tuser_q, tuser_d;
  logic                              tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [31:0]                       pkt_cnt_q, pkt_cnt_d;

  logic [PKT_LEN_WIDTH-1:0]          len_c, last_idx, next_beat;
  logic [PKT_LEN_WIDTH:0]            len_round;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0]  last_keep;
  logic                              beat_hs;

  // Header fields are assembled wire-order (byte 0 in the MSBs), then byte-reversed onto tdata.
  function automatic logic [255:0] byte_swap(input logic [255:0] be);
    logic [255:0] r;
    for (int k = 0; k < 32; k++) r[8*k +: 8] = be[255-8*k -: 8];
    return r;
  endfunction

  function automatic logic [255:0] beat0(input logic [103:0] t, input logic [15:0] len,
                                         input logic [15:0] id, input logic [15:0] csum);
    logic [15:0] tot_len;
    tot_len = len - 16'd14;
    return byte_swap({DST_MAC, SRC_MAC, 16'h0800, 16'h4500, tot_len, id, 16'h4000,
                      8'h40, t[7:0], csum, t[103:72], t[71:56]});
  endfunction

  function automatic logic [255:0] beat1(input logic [103:0] t, input logic [15:0] len);
    logic [15:0] udp_len;
    udp_len = (t[7:0] == 8'd17) ? len - 16'd34 : 16'h0000;
    return byte_swap({t[55:40], t[39:24], t[23:8], udp_len, 192'b0});
  endfunction

`ifdef DFLOW_IP_CSUM_EN
  function automatic logic [15:0] ip_csum(input logic [103:0] t, input logic [15:0] tot_len,
                                          input logic [15:0] id);
    logic [19:0] s;
    s = 20'h04500 + {4'b0, tot_len} + {4'b0, id} + 20'h04000 + {12'h040, t[7:0]}
      + {4'b0, t[103:88]} + {4'b0, t[87:72]} + {4'b0, t[71:56]} + {4'b0, t[55:40]};
    s = {4'b0, s[15:0]} + {16'b0, s[19:16]};
    s = {4'b0, s[15:0]} + {16'b0, s[19:16]};
    return ~s[15:0];
  endfunction
`endif

  assign len_c     = (pkt_len_in < MIN_L) ? MIN_L : ((pkt_len_in > MAX_L) ? MAX_L : pkt_len_in);
  assign len_round = {1'b0, len_q} + (PKT_LEN_WIDTH+1)'(31);
  assign last_idx  = PKT_LEN_WIDTH'((len_round >> 5) - (PKT_LEN_WIDTH+1)'(1));
  assign next_beat = beat_q + PKT_LEN_WIDTH'(1);
  assign last_keep = (len_q[4:0] == 5'd0) ? '1 : ((32'h1 << len_q[4:0]) - 32'h1);
  assign beat_hs   = tvalid_q & m_axis_tready;

  assign tuple_in_ready = (state_q == IDLE) & ~reset;
  assign m_axis_tdata   = tdata_q;
  assign m_axis_tkeep   = tkeep_q;
  assign m_axis_tuser   = tuser_q;
  assign m_axis_tvalid  = tvalid_q;
  assign m_axis_tlast   = tlast_q;
  assign pkt_cnt        = pkt_cnt_q;

  always_comb begin
    state_d   = state_q;
    tuple_d   = tuple_q;
    len_d     = len_q;
    beat_d    = beat_q;
    id_d      = id_q;
    tdata_d   = tdata_q;
    tkeep_d   = tkeep_q;
    tuser_d   = tuser_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    pkt_cnt_d = pkt_cnt_q;
    case (state_q)
      IDLE: begin
        if (tuple_in_vld) begin
          tuple_d = fivetuple_data_in;
          len_d   = len_c;
          id_d    = pkt_cnt_q[15:0];
          tuser_d = {{(C_M_AXIS_TUSER_WIDTH-32){1'b0}}, TUSER_DST_PORT, TUSER_SRC_PORT, len_c};
`ifdef DFLOW_IP_CSUM_EN
          state_d = CSUM;
`else
          state_d  = HDR0;
          tdata_d  = beat0(fivetuple_data_in, len_c, pkt_cnt_q[15:0], 16'h0000);
          tkeep_d  = '1;
          tlast_d  = 1'b0;
          tvalid_d = 1'b1;
          beat_d   = '0;
`endif
        end
      end
`ifdef DFLOW_IP_CSUM_EN
      CSUM: begin
        state_d  = HDR0;
        tdata_d  = beat0(tuple_q, len_q, id_q, ip_csum(tuple_q, len_q - 16'd14, id_q));
        tkeep_d  = '1;
        tlast_d  = 1'b0;
        tvalid_d = 1'b1;
        beat_d   = '0;
      end
`endif
      HDR0: begin
        if (beat_hs) begin
          state_d = HDR1;
          tdata_d = beat1(tuple_q, len_q);
          beat_d  = next_beat;
          tlast_d = (next_beat == last_idx);
          tkeep_d = (next_beat == last_idx) ? last_keep : '1;
        end
      end
      HDR1, BODY: begin
        if (beat_hs) begin
          if (tlast_q) begin
            state_d   = IDLE;
            tvalid_d  = 1'b0;
            tlast_d   = 1'b0;
            pkt_cnt_d = pkt_cnt_q + 32'd1;
          end else begin
            state_d = BODY;
            tdata_d = '0;
            beat_d  = next_beat;
            tlast_d = (next_beat == last_idx);
            tkeep_d = (next_beat == last_idx) ? last_keep : '1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge qdr_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tuple_q   <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      id_q      <= '0;
      tdata_q   <= '0;
      tkeep_q   <= '0;
      tuser_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tuple_q   <= tuple_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      id_q      <= id_d;
      tdata_q   <= tdata_d;
      tkeep_q   <= tkeep_d;
      tuser_q   <= tuser_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

endmodule

// File: tb/tb_dflow_pkt_builder.sv
// Directed bench for dflow_pkt_builder: per-beat frame comparison plus hand-computed field checks.
module tb_dflow_pkt_builder;

  logic         qdr_clk = 1'b0;
  logic         reset;
  logic [103:0] fivetuple_data_in;
  logic [15:0]  pkt_len_in;
  logic         tuple_in_vld;
  logic         tuple_in_ready;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tkeep;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic [31:0]  pkt_cnt;

`ifdef DFLOW_IP_CSUM_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [103:0] TUP_A = {32'h0A000001, 32'h0A000002, 16'd1000, 16'd2000, 8'd17};
  localparam logic [103:0] TUP_B = {32'hC0A80164, 32'h08080808, 16'd443, 16'd51234, 8'd6};

  int           n_vec = 0;
  int           n_err = 0;
  logic [31:0]  model_cnt = '0;
  logic [255:0] cap0, cap1;
  logic [31:0]  cap_keep;
  logic [127:0] cap_tuser;
  int           cap_beats;

  dflow_pkt_builder dut (
    .qdr_clk           (qdr_clk),
    .reset             (reset),
    .fivetuple_data_in (fivetuple_data_in),
    .pkt_len_in        (pkt_len_in),
    .tuple_in_vld      (tuple_in_vld),
    .tuple_in_ready    (tuple_in_ready),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tkeep      (m_axis_tkeep),
    .m_axis_tuser      (m_axis_tuser),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tlast      (m_axis_tlast),
    .pkt_cnt           (pkt_cnt)
  );

  always #5 qdr_clk = ~qdr_clk;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] clamp_len(input logic [15:0] l);
    if (l < 16'd64) return 16'd64;
    if (l > 16'd1518) return 16'd1518;
    return l;
  endfunction

  // Reference frame built byte by byte in wire order.
  function automatic logic [255:0] exp_beat(input logic [103:0] t, input logic [15:0] len,
                                            input logic [15:0] id, input int b);
    logic [7:0]   f [0:63];
    logic [47:0]  dmac, smac;
    logic [15:0]  tl, ul, cs;
    logic [255:0] r;
    int           s;
    dmac = 48'h001122334455;
    smac = 48'h00AABBCCDDEE;
    tl   = len - 16'd14;
    ul   = (t[7:0] == 8'd17) ? len - 16'd34 : 16'h0000;
    for (int i = 0; i < 64; i++) f[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      f[i]     = dmac[47-8*i -: 8];
      f[6+i]   = smac[47-8*i -: 8];
    end
    f[12] = 8'h08; f[14] = 8'h45;
    f[16] = tl[15:8]; f[17] = tl[7:0];
    f[18] = id[15:8]; f[19] = id[7:0];
    f[20] = 8'h40; f[22] = 8'h40; f[23] = t[7:0];
    for (int i = 0; i < 8; i++) f[26+i] = t[103-8*i -: 8];
    f[34] = t[39:32]; f[35] = t[31:24];
    f[36] = t[23:16]; f[37] = t[15:8];
    f[38] = ul[15:8]; f[39] = ul[7:0];
    cs = 16'h0000;
`ifdef DFLOW_IP_CSUM_EN
    s = 0;
    for (int i = 0; i < 10; i++) s += int'({f[14+2*i], f[15+2*i]});
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    cs = ~s[15:0];
`else
    s = 0;
`endif
    f[24] = cs[15:8]; f[25] = cs[7:0];
    r = '0;
    if (b < 2) for (int k = 0; k < 32; k++) r[8*k +: 8] = f[32*b + k];
    return r;
  endfunction

  task automatic run_frame(input logic [103:0] t, input logic [15:0] len_req,
                           input bit rnd, input bit hold, input int abort_at);
    logic [15:0] l;
    logic [15:0] id;
    logic [31:0] ekeep;
    int n, lat, b, guard;
    l  = clamp_len(len_req);
    n  = (int'(l) + 31) / 32;
    id = model_cnt[15:0];
    ekeep = (l[4:0] == 5'd0) ? 32'hFFFFFFFF : ((32'h1 << l[4:0]) - 32'h1);
    fivetuple_data_in = t;
    pkt_len_in        = len_req;
    tuple_in_vld      = 1'b1;
    guard = 0;
    while (!tuple_in_ready && guard < 50) begin
      @(negedge qdr_clk);
      guard++;
    end
    check_eq("accept_ready", tuple_in_ready, 1'b1);
    @(negedge qdr_clk);
    lat = 1;
    if (!hold) tuple_in_vld = 1'b0;
    while (!m_axis_tvalid && lat < 10) begin
      @(negedge qdr_clk);
      lat++;
    end
    check_eq("first_beat_latency", lat, LAT);
    b = 0;
    guard = 0;
    while (b < n && guard < 5000) begin
      check_eq("tvalid_in_frame", m_axis_tvalid, 1'b1);
      check_eq("ready_low_in_frame", tuple_in_ready, 1'b0);
      check_eq("beat_tdata", m_axis_tdata, exp_beat(t, l, id, b));
      check_eq("beat_tkeep", m_axis_tkeep, (b == n-1) ? ekeep : 32'hFFFFFFFF);
      check_eq("beat_tlast", m_axis_tlast, (b == n-1));
      check_eq("beat_tuser", m_axis_tuser, {96'b0, 8'h01, 8'h00, l});
      if (b == abort_at) begin
        reset = 1'b1;
        m_axis_tready = 1'b1;
        @(negedge qdr_clk);
        check_eq("abort_tvalid", m_axis_tvalid, 1'b0);
        check_eq("abort_tlast", m_axis_tlast, 1'b0);
        check_eq("abort_pkt_cnt", pkt_cnt, 32'd0);
        check_eq("abort_ready_in_reset", tuple_in_ready, 1'b0);
        reset = 1'b0;
        model_cnt = '0;
        @(negedge qdr_clk);
        check_eq("abort_ready_after", tuple_in_ready, 1'b1);
        check_eq("abort_tvalid_after", m_axis_tvalid, 1'b0);
        return;
      end
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_axis_tready && m_axis_tvalid) begin
        if (b == 0) cap0 = m_axis_tdata;
        if (b == 1) cap1 = m_axis_tdata;
        cap_keep  = m_axis_tkeep;
        cap_tuser = m_axis_tuser;
        b++;
      end
      @(negedge qdr_clk);
      guard++;
    end
    m_axis_tready = 1'b1;
    cap_beats = b;
    check_eq("frame_complete", b, n);
    model_cnt = model_cnt + 32'd1;
    check_eq("idle_tvalid", m_axis_tvalid, 1'b0);
    check_eq("idle_ready", tuple_in_ready, 1'b1);
    check_eq("pkt_cnt", pkt_cnt, model_cnt);
  endtask

  initial begin
    reset             = 1'b1;
    fivetuple_data_in = '0;
    pkt_len_in        = '0;
    tuple_in_vld      = 1'b0;
    m_axis_tready     = 1'b1;
    repeat (2) @(negedge qdr_clk);
    check_eq("rst_tvalid", m_axis_tvalid, 1'b0);
    check_eq("rst_tlast", m_axis_tlast, 1'b0);
    check_eq("rst_ready", tuple_in_ready, 1'b0);
    check_eq("rst_tdata", m_axis_tdata, 256'h0);
    check_eq("rst_tkeep", m_axis_tkeep, 32'h0);
    check_eq("rst_tuser", m_axis_tuser, 128'h0);
    check_eq("rst_pkt_cnt", pkt_cnt, 32'h0);
    reset = 1'b0;
    @(negedge qdr_clk);
    check_eq("ready_after_rst", tuple_in_ready, 1'b1);

    // 64-byte UDP frame, first after reset (IP id 0)
    run_frame(TUP_A, 16'd64, 1'b0, 1'b0, -1);
    check_eq("t1_beats", cap_beats, 2);
    check_eq("t1_last_keep", cap_keep, 32'hFFFFFFFF);
    check_eq("t1_total_len", {cap0[135:128], cap0[143:136]}, 16'h0032);
    check_eq("t1_udp_len", {cap1[55:48], cap1[63:56]}, 16'h001E);
    check_eq("t1_tuser_len", cap_tuser[15:0], 16'd64);
    check_eq("t1_pkt_cnt", pkt_cnt, 32'd1);
`ifdef DFLOW_IP_CSUM_EN
    check_eq("t1_ip_csum", {cap0[199:192], cap0[207:200]}, 16'h26B9);
`else
    check_eq("t1_ip_csum", {cap0[199:192], cap0[207:200]}, 16'h0000);
`endif

    // len 100, TCP: 4 beats, no UDP length
    run_frame(TUP_B, 16'd100, 1'b0, 1'b0, -1);
    check_eq("t2_beats", cap_beats, 4);
    check_eq("t2_last_keep", cap_keep, 32'h0000000F);
    check_eq("t2_l4_len_zero", {cap1[55:48], cap1[63:56]}, 16'h0000);
    check_eq("t2_ip_id", {cap0[151:144], cap0[159:152]}, 16'h0001);

    run_frame(TUP_A, 16'd10, 1'b0, 1'b0, -1);
    check_eq("t3_beats", cap_beats, 2);
    check_eq("t3_tuser_len", cap_tuser[15:0], 16'd64);

    run_frame(TUP_B, 16'd2000, 1'b0, 1'b0, -1);
    check_eq("t4_beats", cap_beats, 48);
    check_eq("t4_last_keep", cap_keep, 32'h00003FFF);
    check_eq("t4_tuser_len", cap_tuser[15:0], 16'd1518);

    // 300 bytes with random backpressure
    run_frame(TUP_A, 16'd300, 1'b1, 1'b0, -1);
    check_eq("t5_beats", cap_beats, 10);
    check_eq("t5_last_keep", cap_keep, 32'h00000FFF);

    // reset during beat 5 of a max-length frame
    run_frame(TUP_B, 16'd1518, 1'b0, 1'b0, 5);

    // back-to-back descriptors, vld held high: ids 0,1,2
    for (int i = 0; i < 3; i++) begin
      run_frame(TUP_A, 16'd64, 1'b0, 1'b1, -1);
      check_eq("b2b_ip_id", {cap0[151:144], cap0[159:152]}, 16'(i));
    end
    tuple_in_vld = 1'b0;
    repeat (2) @(negedge qdr_clk);
    check_eq("final_pkt_cnt", pkt_cnt, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
